spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Single-byte SPI master, the initiator counterpart of the team's SPI slave peripheral.
- Takes a byte over a valid/ready strobe interface and shifts it out MSB-first on mosi_o while capturing miso_i.
- Generates sck_o and a per-byte cs_o.
- Returns the received byte with a one-cycle valid pulse; intended to sit behind a wishbone slave wrapper or drive an off-chip SPI device.

Parameters:
CLKS_PER_HALF_BIT, 2, clk_i cycles per SPI half period; legal >= 2
CPOL, 0, sck_o idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing
CS_INACTIVE_CLKS, 1, clk_i cycles cs_o stays high after a byte before tx_ready_o returns; legal >= 1

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
tx_dv_i  input  1  byte request strobe; accepted only when tx_ready_o = 1
tx_byte_i  input  8  byte to transmit, captured with accepted tx_dv_i
tx_ready_o  output  1  high in IDLE; master can accept a byte
rx_dv_o  output  1  one-cycle pulse, rx_byte_o valid
rx_byte_o  output  8  last received byte, held until next rx_dv_o
sck_o  output  1  SPI clock
cs_o  output  1  chip select, active low
mosi_o  output  1  serial data out
miso_i  input  1  serial data in; treated as synchronous to clk_i

Behaviour:
- Reset values (while rst_i = 1 and in the first cycle after it): cs_o = 1, sck_o = CPOL, mosi_o = 0, rx_dv_o = 0, rx_byte_o = 0x00, state = IDLE, counters = 0.
- tx_ready_o = 0 while rst_i = 1; it is 1 in IDLE after reset.
- Reset mid-transfer aborts immediately (same cycle): cs_o back to 1 next cycle, no rx_dv_o pulse.
- States: IDLE -> CS_SETUP -> TRANSFER -> CS_HOLD -> CS_GAP -> IDLE.
- IDLE:
  - tx_ready_o = 1, cs_o = 1, sck_o = CPOL.
  - tx_dv_i = 1 latches tx_byte_i into the shift register and moves to CS_SETUP.
  - tx_dv_i is ignored in every other state.
- CS_SETUP:
  - Lasts CLKS_PER_HALF_BIT cycles.
  - cs_o = 0, mosi_o = tx bit 7, sck_o = CPOL, tx_ready_o = 0.
- TRANSFER:
  - 16 sck_o edges, one every CLKS_PER_HALF_BIT cycles.
  - Edge 1 occurs in the first TRANSFER cycle.
  - Odd edges are leading (sck_o = !CPOL); even edges are trailing (sck_o = CPOL).
  - After edge 16 the state moves to CS_HOLD.
- Edges by mode:
  - CPHA = 0: sample at odd edges 1..15; mosi_o advances to the next bit at even edges 2..14; edge 16 shifts nothing.
  - CPHA = 1: mosi_o keeps bit 7 at edge 1; mosi_o advances at odd edges 3..15; sample at even edges 2..16.
- Sampling:
  - "Sample" means miso_i is captured at the end of the cycle in which sck_o first shows the sampling level.
  - Bits shift into rx_shift LSB-side, so the first bit sampled ends as bit 7.
- CS_HOLD:
  - Lasts CLKS_PER_HALF_BIT cycles, starting in the cycle edge 16 appears.
  - cs_o = 0, sck_o = CPOL.
- CS_GAP:
  - Lasts CS_INACTIVE_CLKS cycles, cs_o = 1.
  - In its first cycle: rx_dv_o = 1 and rx_byte_o = rx_shift.
  - Then returns to IDLE.
- Latency (CLKS_PER_HALF_BIT = H, CS_INACTIVE_CLKS = G), accept at cycle 0:
  - cs_o low at cycle 1.
  - Edge k appears at cycle 1 + k·H.
  - rx_dv_o at cycle 1 + 17·H.
  - tx_ready_o high at cycle 1 + 17·H + G.
  - Defaults (H = 2, G = 1): edge 1 at cycle 3, rx_dv_o at 35, ready at 36.
- Back-to-back: tx_dv_i held high re-accepts in the first IDLE cycle, so cs_o is high for exactly G+1 cycles between bytes.
- mosi_o returns to 0 in CS_GAP and IDLE.
- Counters: the half-bit counter wraps 0..H-1; the edge counter is 5 bits, range 0..16.

Test Plan:
1. Defaults, tx_byte_i = 0xA5, miso_i driven by bench slave model with 0x3C in mode 0 → mosi_o bit stream 1,0,1,0,0,1,0,1; sck_o edges 1/16 at cycles 3/33; rx_dv_o single pulse at cycle 35 with rx_byte_o = 0x3C; tx_ready_o = 1 at cycle 36.
2. Loopback mosi_o → miso_i, bytes 0x00, 0xFF, 0x81 back-to-back with tx_dv_i held high → rx_byte_o = 0x00, 0xFF, 0x81 in order; cs_o high exactly 2 cycles between bytes; three rx_dv_o pulses.
3. tx_dv_i = 1 with tx_byte_i = 0x55 at cycle 10 of a 0xA5 transfer → ignored; only 0xA5 is transmitted; no extra cs_o cycle.
4. rst_i = 1 for one cycle at cycle 20 of a transfer → next cycle cs_o = 1, sck_o = CPOL, mosi_o = 0, rx_dv_o = 0; tx_ready_o = 1; a new 0xC3 transfer then completes normally.
5. Instances CPOL = 1/CPHA = 1 and CPOL = 0/CPHA = 1 with H = 3, loopback 0x96 → sck_o idles at CPOL; sampling on trailing edges; rx_byte_o = 0x96; rx_dv_o at cycle 1 + 51 = 52.
6. Slave model holding miso_i = 1 for one byte → rx_byte_o = 0xFF; then miso_i = 0 → rx_byte_o = 0x00; rx_byte_o holds its value between rx_dv_o pulses.

Source files
------------

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// spi_master_if : byte strobe interface plus SPI pins of the SPI master
// Rev 1.0
// ============================================================================
interface spi_master_if;
    logic       tx_dv_i;
    logic [7:0] tx_byte_i;
    logic       tx_ready_o;
    logic       rx_dv_o;
    logic [7:0] rx_byte_o;
    logic       sck_o;
    logic       cs_o;
    logic       mosi_o;
    logic       miso_i;

    modport master (
        input  tx_dv_i, tx_byte_i, miso_i,
        output tx_ready_o, rx_dv_o, rx_byte_o, sck_o, cs_o, mosi_o
    );

    modport slave (
        output tx_dv_i, tx_byte_i, miso_i,
        input  tx_ready_o, rx_dv_o, rx_byte_o, sck_o, cs_o, mosi_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : single-byte SPI master, MSB first, CPOL/CPHA configurable
// Rev 1.0
// ============================================================================
module spi_master #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter bit CPOL              = 1'b0,
    parameter bit CPHA              = 1'b0,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    spi_master_if.master bus
);
    localparam int c_HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int c_GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [c_HW-1:0] c_HALF_LAST = c_HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_TRANSFER = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_CS_GAP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [c_HW-1:0] half_q, half_d;
    logic [4:0]      edge_q, edge_d;
    logic [c_GW-1:0] gap_q, gap_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_dv_q, rx_dv_d;

    logic [4:0]      w_edge_next;
    logic            w_sample;
    logic            w_shift;
    logic            w_active;

    // edge_q is the number of sck edges already shown on sck_o
    assign w_edge_next = edge_q + 5'd1;
    assign w_sample    = CPHA ? ~edge_q[0] : edge_q[0];
    assign w_shift     = CPHA ? (w_edge_next[0] && (w_edge_next >= 5'd3))
                              : (!w_edge_next[0] && (w_edge_next <= 5'd14));
    assign w_active    = (state_q == ST_CS_SETUP) || (state_q == ST_TRANSFER) ||
                         (state_q == ST_CS_HOLD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            half_q     <= '0;
            edge_q     <= '0;
            gap_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            edge_q     <= edge_d;
            gap_q      <= gap_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        edge_d     = edge_q;
        gap_d      = gap_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                half_d = '0;
                edge_d = '0;
                gap_d  = '0;
                if (bus.tx_dv_i) begin
                    tx_shift_d = bus.tx_byte_i;
                    state_d    = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (half_q == c_HALF_LAST) begin
                    half_d  = '0;
                    edge_d  = 5'd1;
                    state_d = ST_TRANSFER;
                end else begin
                    half_d = half_q + c_HW'(1);
                end
            end
            ST_TRANSFER: begin
                // miso is taken at the end of the first cycle showing a sampling level
                if ((half_q == '0) && w_sample) begin
                    rx_shift_d = {rx_shift_q[6:0], bus.miso_i};
                end
                if (half_q == c_HALF_LAST) begin
                    half_d = '0;
                    edge_d = w_edge_next;
                    if (w_shift) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (edge_q == 5'd15) begin
                        state_d = ST_CS_HOLD;
                    end
                end else begin
                    half_d = half_q + c_HW'(1);
                end
            end
            ST_CS_HOLD: begin
                // edge 16 is a sampling edge only when CPHA = 1
                if (CPHA && (half_q == '0)) begin
                    rx_shift_d = {rx_shift_q[6:0], bus.miso_i};
                end
                if (half_q == c_HALF_LAST) begin
                    half_d    = '0;
                    edge_d    = '0;
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_shift_q;
                    state_d   = ST_CS_GAP;
                end else begin
                    half_d = half_q + c_HW'(1);
                end
            end
            ST_CS_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + c_GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // rst_i gates the pins directly so a mid-transfer reset releases the bus at once
    assign bus.tx_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign bus.cs_o       = rst_i || !w_active;
    assign bus.sck_o      = rst_i ? CPOL : (CPOL ^ ((state_q == ST_TRANSFER) && edge_q[0]));
    assign bus.mosi_o     = !rst_i && w_active && tx_shift_q[7];
    assign bus.rx_dv_o    = rx_dv_q && !rst_i;
    assign bus.rx_byte_o  = rx_byte_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spi_master : randomized scoreboard bench for spi_master (three configurations)
// Rev 1.0
// ============================================================================
module tb_spi_master;
    localparam int H0 = 2;
    localparam int G0 = 1;
    localparam int H1 = 3;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst12 = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_if bus0();
    spi_master_if bus1();
    spi_master_if bus2();

    spi_master #(.CLKS_PER_HALF_BIT(H0), .CPOL(1'b0), .CPHA(1'b0), .CS_INACTIVE_CLKS(G0))
        u_dut0 (.clk_i(clk), .rst_i(rst0), .bus(bus0));
    spi_master #(.CLKS_PER_HALF_BIT(H1), .CPOL(1'b1), .CPHA(1'b1), .CS_INACTIVE_CLKS(1))
        u_dut1 (.clk_i(clk), .rst_i(rst12), .bus(bus1));
    spi_master #(.CLKS_PER_HALF_BIT(H1), .CPOL(1'b0), .CPHA(1'b1), .CS_INACTIVE_CLKS(1))
        u_dut2 (.clk_i(clk), .rst_i(rst12), .bus(bus2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DUT0 slave model: 0 loopback, 1 shift s_byte, 2 ones, 3 zeros
    int         smode = 0;
    logic [7:0] s_byte = 8'h00;
    logic [7:0] s_sr = 8'h00;
    assign bus0.miso_i = (smode == 0) ? bus0.mosi_o :
                         (smode == 1) ? s_sr[7]     : (smode == 2);
    assign bus1.miso_i = bus1.mosi_o;
    assign bus2.miso_i = bus2.mosi_o;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         t_acc_q[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    int         ta12[$];

    bit         prev_cs = 1'b1, prev_sck = 1'b0, prev_rdy = 1'b0;
    bit         rdy_pending = 1'b0, gap_chk = 1'b0;
    int         edge_n = 0, nbits = 0, cs_falls = 0, rx_cnt = 0, cs_hi_run = 0, rdy_due = 0;
    logic [7:0] cap = 8'h00, last_rx = 8'h00;

    // DUT0 monitor: protocol-level slave view plus scoreboard pop on rx_dv_o
    always @(negedge clk) begin
        if (rst0) begin
            exp_rx.delete();
            exp_tx.delete();
            t_acc_q.delete();
            rdy_pending = 1'b0;
            last_rx = 8'h00;
        end else begin
            if (prev_cs && !bus0.cs_o) begin
                cs_falls++;
                edge_n = 0;
                nbits = 0;
                cap = 8'h00;
                s_sr = s_byte;
                check("rx_hold", 32'(bus0.rx_byte_o), 32'(last_rx));
                if (gap_chk) check("cs_gap_len", cs_hi_run, G0 + 1);
            end
            if (!bus0.cs_o && (bus0.sck_o !== prev_sck)) begin
                edge_n++;
                if (t_acc_q.size() != 0) begin
                    if (edge_n == 1)  check("edge1_cycle", cyc - t_acc_q[0], 1 + H0);
                    if (edge_n == 16) check("edge16_cycle", cyc - t_acc_q[0], 1 + 16 * H0);
                end
                if (bus0.sck_o) begin
                    cap = {cap[6:0], bus0.mosi_o};
                    nbits++;
                end else begin
                    s_sr = {s_sr[6:0], 1'b0};
                end
            end
            if (!prev_cs && bus0.cs_o) begin
                check("edge_count", edge_n, 16);
                check("mosi_nbits", nbits, 8);
                if (exp_tx.size() != 0) check("mosi_byte", 32'(cap), 32'(exp_tx.pop_front()));
                else check("unexpected_cs_frame", 1, 0);
                cs_hi_run = 0;
            end
            if (bus0.cs_o) cs_hi_run++;
            if (bus0.rx_dv_o) begin
                rx_cnt++;
                if (exp_rx.size() == 0) begin
                    check("unexpected_rx_dv", 1, 0);
                end else begin
                    check("rx_byte", 32'(bus0.rx_byte_o), 32'(exp_rx.pop_front()));
                    check("rx_dv_cycle", cyc - t_acc_q.pop_front(), 1 + 17 * H0);
                    rdy_due = cyc + G0;
                    rdy_pending = 1'b1;
                end
                last_rx = bus0.rx_byte_o;
            end
            if (!prev_rdy && bus0.tx_ready_o && rdy_pending) begin
                check("ready_cycle", cyc, rdy_due);
                rdy_pending = 1'b0;
            end
        end
        prev_cs = bus0.cs_o;
        prev_sck = bus0.sck_o;
        prev_rdy = bus0.tx_ready_o;
    end

    // DUT1/DUT2 monitor: loopback result, latency and idle clock level
    always @(negedge clk) begin
        if (!rst12) begin
            if (bus1.rx_dv_o) begin
                if (exp1.size() == 0) check("b1_unexpected_rx_dv", 1, 0);
                else begin
                    check("b1_rx_byte", 32'(bus1.rx_byte_o), 32'(exp1.pop_front()));
                    check("b1_rx_dv_cycle", cyc - ta12[0], 1 + 17 * H1);
                    check("b1_sck_idle", 32'(bus1.sck_o), 1);
                end
            end
            if (bus2.rx_dv_o) begin
                if (exp2.size() == 0) check("b2_unexpected_rx_dv", 1, 0);
                else begin
                    check("b2_rx_byte", 32'(bus2.rx_byte_o), 32'(exp2.pop_front()));
                    check("b2_rx_dv_cycle", cyc - ta12.pop_front(), 1 + 17 * H1);
                    check("b2_sck_idle", 32'(bus2.sck_o), 0);
                end
            end
        end
    end

    function automatic logic [7:0] model_rx(input logic [7:0] b, input int sm, input logic [7:0] sb);
        case (sm)
            0:       return b;
            1:       return sb;
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic send0(input logic [7:0] b, input int sm, input logic [7:0] sb, input bit hold);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus0.tx_ready_o) begin
            g++;
            if (g > 500) begin
                check("send0_ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        smode = sm;
        s_byte = sb;
        bus0.tx_dv_i = 1'b1;
        bus0.tx_byte_i = b;
        exp_tx.push_back(b);
        exp_rx.push_back(model_rx(b, sm, sb));
        t_acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        if (!hold) bus0.tx_dv_i = 1'b0;
    endtask

    task automatic wait_idle0();
        int g;
        g = 0;
        while ((exp_rx.size() != 0 || !bus0.tx_ready_o) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("idle0_timeout", 32'(g < 3000), 1);
    endtask

    task automatic send12(input logic [7:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!(bus1.tx_ready_o && bus2.tx_ready_o)) begin
            g++;
            if (g > 500) begin
                check("send12_ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        bus1.tx_dv_i = 1'b1;
        bus1.tx_byte_i = b;
        bus2.tx_dv_i = 1'b1;
        bus2.tx_byte_i = b;
        exp1.push_back(b);
        exp2.push_back(b);
        ta12.push_back(cyc);
        @(posedge clk);
        #1;
        bus1.tx_dv_i = 1'b0;
        bus2.tx_dv_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         falls0, rx0, g;
        bit         prev_hold, h;
        logic [7:0] b, sb;
        int         sm;

        bus0.tx_dv_i = 1'b0; bus0.tx_byte_i = 8'h00;
        bus1.tx_dv_i = 1'b0; bus1.tx_byte_i = 8'h00;
        bus2.tx_dv_i = 1'b0; bus2.tx_byte_i = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(bus0.tx_ready_o), 0);
        check("rst_cs", 32'(bus0.cs_o), 1);
        check("rst_sck", 32'(bus0.sck_o), 0);
        check("rst_mosi", 32'(bus0.mosi_o), 0);
        check("rst_rx_dv", 32'(bus0.rx_dv_o), 0);
        check("rst_rx_byte", 32'(bus0.rx_byte_o), 0);
        check("b1_rst_sck", 32'(bus1.sck_o), 1);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst12 = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus0.tx_ready_o), 1);
        check("post_rst_cs", 32'(bus0.cs_o), 1);
        check("b1_post_rst_ready", 32'(bus1.tx_ready_o), 1);

        fork
            begin
                // basic mode-0 byte against a shifting slave
                send0(8'hA5, 1, 8'h3C, 1'b0);
                wait_idle0();

                // loopback, back to back with the strobe held
                rx0 = rx_cnt;
                send0(8'h00, 0, 8'h00, 1'b1);
                @(posedge clk); #1; gap_chk = 1'b1;
                send0(8'hFF, 0, 8'h00, 1'b1);
                send0(8'h81, 0, 8'h00, 1'b0);
                @(posedge clk); #1; gap_chk = 1'b0;
                wait_idle0();
                check("b2b_rx_pulses", rx_cnt - rx0, 3);

                // strobe during a transfer is ignored
                falls0 = cs_falls;
                send0(8'hA5, 1, 8'h5A, 1'b0);
                repeat (9) @(negedge clk);
                bus0.tx_dv_i = 1'b1;
                bus0.tx_byte_i = 8'h55;
                @(posedge clk); #1;
                bus0.tx_dv_i = 1'b0;
                wait_idle0();
                repeat (5) @(negedge clk);
                check("ignored_strobe_frames", cs_falls - falls0, 1);

                // reset in the middle of a transfer
                rx0 = rx_cnt;
                send0(8'hA5, 1, 8'h77, 1'b0);
                repeat (19) @(posedge clk);
                #1; rst0 = 1'b1;
                @(negedge clk);
                check("midrst_tx_ready", 32'(bus0.tx_ready_o), 0);
                check("midrst_cs", 32'(bus0.cs_o), 1);
                @(posedge clk); #1; rst0 = 1'b0;
                @(negedge clk);
                check("abort_cs", 32'(bus0.cs_o), 1);
                check("abort_sck", 32'(bus0.sck_o), 0);
                check("abort_mosi", 32'(bus0.mosi_o), 0);
                check("abort_rx_dv", 32'(bus0.rx_dv_o), 0);
                check("abort_ready", 32'(bus0.tx_ready_o), 1);
                repeat (60) @(negedge clk);
                check("abort_no_rx_dv", rx_cnt - rx0, 0);
                send0(8'hC3, 0, 8'h00, 1'b0);
                wait_idle0();

                // constant miso levels, result held between pulses
                send0(8'h12, 2, 8'h00, 1'b0);
                wait_idle0();
                repeat (7) @(negedge clk);
                check("hold_ff", 32'(bus0.rx_byte_o), 32'hFF);
                send0(8'h34, 3, 8'h00, 1'b0);
                wait_idle0();
                repeat (7) @(negedge clk);
                check("hold_00", 32'(bus0.rx_byte_o), 32'h00);

                // randomized traffic
                prev_hold = 1'b0;
                for (int i = 0; i < 24; i++) begin
                    b = 8'($urandom);
                    sb = 8'($urandom);
                    sm = int'($urandom_range(0, 3));
                    h = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
                    send0(b, sm, sb, h);
                    prev_hold = h;
                end
                wait_idle0();
            end
            begin
                send12(8'h96);
                for (int i = 0; i < 6; i++) send12(8'($urandom));
                g = 0;
                while ((exp1.size() != 0 || exp2.size() != 0) && g < 3000) begin
                    @(negedge clk);
                    g++;
                end
                check("idle12_timeout", 32'(g < 3000), 1);
            end
        join

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
